uart_rx_param: RTL and testbench



---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_baud_cnt.sv | 43 ++++
 rtl/uart_rx_param.sv | 240 ++++++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver (and a future TX).
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
package uart_pkg;

    // Receive FSM states; PARITY only exists when UART_RX_PARITY_EN is defined.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY    = 3'd3,
`endif
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } uart_state_e;

    // Fewer than 4 clocks per bit leaves no room for a meaningful mid-bit sample.
    localparam int MIN_CLKS_PER_BIT = 4;

    // Clocks per serial bit, truncating.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    function automatic bit data_bits_legal(input int n);
        return (n >= 5) && (n <= 9);
    endfunction

    function automatic bit stop_bits_legal(input int n);
        return (n >= 1) && (n <= 2);
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter producing half-bit and full-bit terminal-count strobes.
// Latency: strobes are combinational from the counter register.
// Backpressure: none; clr_i has priority over en_i, counter wraps on full.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic half_o,
    output logic full_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_TC = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_TC = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign half_o = en_i && (cnt_q == HALF_TC);
    assign full_o = en_i && (cnt_q == FULL_TC);

    // Next count: clear wins, otherwise count and wrap at the end of a bit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = full_o ? '0 : cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver (optional parity via UART_RX_PARITY_EN) with valid/ready output.
// Latency: valid_o rises 2 + CPB/2 + (DATA_BITS + P + STOP_BITS) * CPB + 1 clocks after the start edge.
// Backpressure: a frame completing while valid_o is held is dropped and flagged on overrun_o.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD      = 115_200,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rx_i,
`ifdef UART_RX_PARITY_EN
    input  logic                 parity_odd_i,
    output logic                 parity_err_o,
`endif
    input  logic                 ready_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    output logic                 frame_err_o,
    output logic                 overrun_o,
    output logic                 busy_o
);

    localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
    localparam int BW  = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    if (CPB < MIN_CLKS_PER_BIT) begin : g_bad_cpb
        $error("uart_rx_param: CLK_FREQ/BAUD must be at least 4");
    end
    if (!data_bits_legal(DATA_BITS)) begin : g_bad_data_bits
        $error("uart_rx_param: DATA_BITS must be 5..9");
    end
    if (!stop_bits_legal(STOP_BITS)) begin : g_bad_stop_bits
        $error("uart_rx_param: STOP_BITS must be 1..2");
    end

    uart_state_e          state_q, state_d;
    logic                 rx_m_q, rx_s_q;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic                 ferr_q, ferr_d;
    logic                 commit_q, commit_d;
    logic                 baud_clr, baud_en, half_tick, full_tick;

    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
    logic                 perr_q, perr_d;
    logic                 parity_err_q, parity_err_d;
`endif

    uart_baud_cnt #(
        .CLKS_PER_BIT (CPB)
    ) u_baud (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (baud_clr),
        .en_i   (baud_en),
        .half_o (half_tick),
        .full_o (full_tick)
    );

    // Frame FSM: start validation, LSB-first shift, parity and stop sampling.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        ferr_d    = ferr_q;
        commit_d  = 1'b0;
        baud_clr  = 1'b0;
        baud_en   = (state_q != WAIT_HIGH);
`ifdef UART_RX_PARITY_EN
        perr_d    = perr_q;
`endif
        case (state_q)
            IDLE: begin
                // Hold the counter at 0 while idle; the edge-detect cycle is
                // the first cycle of the half-bit wait.
                baud_clr = rx_s_q;
                if (!rx_s_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (half_tick) begin
                    baud_clr = 1'b1;
                    if (rx_s_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                        ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
                        perr_d    = 1'b0;
`endif
                    end
                end
            end
            DATA: begin
                if (full_tick) begin
                    shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d   = PARITY;
`else
                        state_d   = STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (full_tick) begin
                    perr_d  = ((^shift_q) ^ rx_s_q) != parity_odd_i;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (full_tick) begin
                    if (!rx_s_q) begin
                        ferr_d = 1'b1;
                    end
                    if (bit_cnt_q == LAST_STOP) begin
                        bit_cnt_d = '0;
                        commit_d  = 1'b1;
                        // A low last stop bit means a break: wait for the line to recover.
                        state_d   = rx_s_q ? IDLE : WAIT_HIGH;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            WAIT_HIGH: begin
                baud_clr = 1'b1;
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Synchroniser and frame FSM registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_m_q    <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            ferr_q    <= 1'b0;
            commit_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q    <= 1'b0;
`endif
        end else begin
            rx_m_q    <= rx_i;
            rx_s_q    <= rx_m_q;
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            ferr_q    <= ferr_d;
            commit_q  <= commit_d;
`ifdef UART_RX_PARITY_EN
            perr_q    <= perr_d;
`endif
        end
    end

    // Output holding register: consume, commit or drop with overrun.
    always_comb begin
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = frame_err_q;
        overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_err_d = parity_err_q;
`endif
        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
        if (commit_q) begin
            // A consume in the commit cycle frees the slot for the new frame.
            if (!valid_q || ready_i) begin
                data_d      = shift_q;
                frame_err_d = ferr_q;
                valid_d     = 1'b1;
`ifdef UART_RX_PARITY_EN
                parity_err_d = perr_q;
`endif
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // Output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;
    assign busy_o      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err_o = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: directed scenarios plus random frames, checked by a scoreboard.
// Expected frames are queued when a frame is sent; a negedge monitor pops on each handshake.
// Builds with or without UART_RX_PARITY_EN.
module tb_uart_rx_param;

`ifdef UART_RX_PARITY_EN
    localparam int DB = 7;
    localparam int SB = 2;
    localparam int P  = 1;
`else
    localparam int DB = 8;
    localparam int SB = 1;
    localparam int P  = 0;
`endif
    localparam int CPB = 1_000_000 / 62_500;
    localparam int LAT = 2 + CPB / 2 + (DB + P + SB) * CPB + 1;

    typedef struct {
        int data;
        int ferr;
        int perr;
    } exp_t;

    exp_t exp_q[$];

    logic          clk = 1'b0;
    logic          rst_i, rx_i, ready_i;
    logic [DB-1:0] data_o;
    logic          valid_o, frame_err_o, overrun_o, busy_o;
    logic          parity_odd_i;
    logic          parity_err_o;

    int errors = 0, checks = 0;
    int cyc = 0, start_cyc = 0;
    int last_lat = 0, last_run = 0, run_len = 0;
    int ovr_cnt = 0, rise_cnt = 0;
    bit prev_v = 1'b0;
    bit rnd_done;

    uart_rx_param #(
        .CLK_FREQ  (1_000_000),
        .BAUD      (62_500),
        .DATA_BITS (DB),
        .STOP_BITS (SB)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .rx_i         (rx_i),
`ifdef UART_RX_PARITY_EN
        .parity_odd_i (parity_odd_i),
        .parity_err_o (parity_err_o),
`endif
        .ready_i      (ready_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .frame_err_o  (frame_err_o),
        .overrun_o    (overrun_o),
        .busy_o       (busy_o)
    );

`ifndef UART_RX_PARITY_EN
    assign parity_err_o = 1'b0;
`endif

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endfunction

    // Monitor: latency/pulse bookkeeping and scoreboard pop on every handshake.
    always @(negedge clk) begin
        if (rst_i) begin
            prev_v  = 1'b0;
            run_len = 0;
        end else begin
            if (valid_o && !prev_v) begin
                last_lat = cyc - start_cyc;
                rise_cnt++;
            end
            if (valid_o) begin
                run_len++;
            end else if (run_len != 0) begin
                last_run = run_len;
                run_len  = 0;
            end
            if (overrun_o) ovr_cnt++;
            if (valid_o && ready_i) begin
                chk("frame_expected", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("data", int'(data_o), e.data);
                    chk("frame_err", int'(frame_err_o), e.ferr);
`ifdef UART_RX_PARITY_EN
                    chk("parity_err", int'(parity_err_o), e.perr);
`endif
                end
            end
            prev_v = valid_o;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one frame; the line is left at the level of the last stop bit.
    task automatic send_frame(input int d, input bit bad_s0, input bit bad_s1,
                              input bit bad_par, input bit expect_it);
        exp_t e;
        int   dm;
        int   ones;
        dm   = d & ((1 << DB) - 1);
        ones = 0;
        for (int i = 0; i < DB; i++) ones += (dm >> i) & 1;
        e.data = dm;
        e.ferr = int'(bad_s0 || (SB == 2 && bad_s1));
        e.perr = (P == 1) ? int'(bad_par) : 0;
        if (expect_it) exp_q.push_back(e);
        rx_i      = 1'b0;
        start_cyc = cyc;
        tick(CPB);
        for (int i = 0; i < DB; i++) begin
            rx_i = ((dm >> i) & 1) != 0;
            tick(CPB);
        end
        if (P == 1) begin
            // Parity bit makes the total count of ones odd (odd mode) or even.
            rx_i = ((ones % 2) == 1) ? ~parity_odd_i : parity_odd_i;
            if (bad_par) rx_i = ~rx_i;
            tick(CPB);
        end
        rx_i = !bad_s0;
        tick(CPB);
        if (SB == 2) begin
            rx_i = !bad_s1;
            tick(CPB);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_data"}, int'(data_o), 0);
        chk({tag, "_valid"}, int'(valid_o), 0);
        chk({tag, "_frame_err"}, int'(frame_err_o), 0);
        chk({tag, "_overrun"}, int'(overrun_o), 0);
        chk({tag, "_busy"}, int'(busy_o), 0);
`ifdef UART_RX_PARITY_EN
        chk({tag, "_parity_err"}, int'(parity_err_o), 0);
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, o0;
        rst_i        = 1'b1;
        rx_i         = 1'b1;
        ready_i      = 1'b0;
        parity_odd_i = 1'b1;
        rnd_done     = 1'b0;
        tick(4);
        check_reset_outputs("reset");
        rst_i = 1'b0;
        tick(20);

        // Single frame, consumer always ready: latency and one-cycle valid.
        ready_i = 1'b1;
        send_frame(32'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(2 * CPB);
        chk("latency", last_lat, LAT);
        chk("valid_width", last_run, 1);

        // Short low glitch on an idle line.
        r0   = rise_cnt;
        rx_i = 1'b0;
        tick(4);
        rx_i = 1'b1;
        tick(1);
        chk("glitch_busy_high", int'(busy_o), 1);
        tick(10);
        chk("glitch_busy_low", int'(busy_o), 0);
        tick(2 * CPB);
        chk("glitch_no_frame", rise_cnt - r0, 0);

        // Break: stop bit low and the line held low for 30 bit times.
        r0 = rise_cnt;
        send_frame(32'h5A, 1'b1, 1'b1, 1'b0, 1'b1);
        tick(30 * CPB);
        chk("break_wait_high_busy", int'(busy_o), 1);
        chk("break_one_frame", rise_cnt - r0, 1);
        rx_i = 1'b1;
        tick(10);
        chk("break_recover_idle", int'(busy_o), 0);
        tick(2 * CPB);
        chk("break_no_extra_frame", rise_cnt - r0, 1);

        // Overrun: consumer stalled across two back-to-back frames.
        ready_i = 1'b0;
        o0      = ovr_cnt;
        send_frame(32'h11, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(32'h22, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(4);
        chk("overrun_data_kept", int'(data_o), 32'h11);
        chk("overrun_valid_held", int'(valid_o), 1);
        chk("overrun_pulses", ovr_cnt - o0, 1);
        ready_i = 1'b1;
        tick(1);
        chk("valid_drop_after_consume", int'(valid_o), 0);

        // Consume exactly in the commit cycle of the next frame.
        ready_i = 1'b0;
        send_frame(32'h33, 1'b0, 1'b0, 1'b0, 1'b1);
        o0 = ovr_cnt;
        fork
            send_frame(32'h44, 1'b0, 1'b0, 1'b0, 1'b1);
            begin
                tick(LAT - 1);
                ready_i = 1'b1;
                tick(1);
                ready_i = 1'b0;
            end
        join
        chk("commit_consume_no_overrun", ovr_cnt - o0, 0);
        chk("commit_consume_data", int'(data_o), 32'h44);
        chk("commit_consume_valid", int'(valid_o), 1);
        ready_i = 1'b1;
        tick(2);

`ifdef UART_RX_PARITY_EN
        // Wrong parity bit on 0x41, odd parity.
        send_frame(32'h41, 1'b0, 1'b0, 1'b1, 1'b1);
        tick(CPB);
`endif

        // Reset in the middle of a frame aborts it without output.
        rx_i = 1'b0;
        tick(CPB);
        rx_i = 1'b1;
        tick(3 * CPB);
        chk("busy_mid_frame", int'(busy_o), 1);
        rst_i = 1'b1;
        tick(2);
        check_reset_outputs("mid_reset");
        rst_i = 1'b0;
        tick(3 * CPB);
        send_frame(32'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
        rx_i = 1'b1;
        tick(2 * CPB);

        // Random frames with random stop/parity errors and a random consumer.
        fork
            begin
                for (int n = 0; n < 25; n++) begin
                    send_frame(int'($urandom_range(0, 511)),
                               $urandom_range(0, 3) == 0,
                               $urandom_range(0, 3) == 0,
                               $urandom_range(0, 3) == 0,
                               1'b1);
                    rx_i = 1'b1;
                    tick(int'($urandom_range(4, 40)));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    tick(1);
                    ready_i = $urandom_range(0, 1) == 1;
                end
            end
        join
        ready_i = 1'b1;
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) tick(1);
        chk("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
